// File: rtl/t08_lsu_pkg.sv
// Definitions shared across the t08 datapath: ALU operation codes and the
// load/store unit state encoding.
package t08_pkg;

    // Codes 1-35 belong to the ALU; only those the LSU and its tests use are named.
    typedef enum logic [5:0] {
        ALU_ADD = 6'd1,
        ALU_LB  = 6'd20,
        ALU_LH  = 6'd21,
        ALU_LW  = 6'd22,
        ALU_LBU = 6'd23,
        ALU_LHU = 6'd24,
        ALU_SB  = 6'd25,
        ALU_SH  = 6'd26,
        ALU_SW  = 6'd27
    } alu_operations;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } lsu_state_t;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op >= 6'd20) && (op <= 6'd27);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op >= 6'd25) && (op <= 6'd27);
    endfunction

endpackage

// File: rtl/t08_lsu_if.sv
// Word-wide request/acknowledge data bus between the LSU (master) and memory (slave).
interface t08_lsu_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_sel;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_sel,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_sel,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/t08_lsu_align.sv
// Combinational byte-lane steering: alignment check, byte enables, write-data
// replication and load-data extraction with sign/zero extension.
module t08_lsu_align
    import t08_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic        misaligned,
    output logic [3:0]  sel,
    output logic [31:0] wdata,
    output logic [31:0] load_value
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte  = rdata[{addr_lo, 3'b000} +: 8];
        lane_half  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        misaligned = 1'b0;
        sel        = 4'b0000;
        wdata      = 32'h0;
        load_value = 32'h0;

        case (op)
            ALU_LB, ALU_LBU, ALU_SB: sel = 4'b0001 << addr_lo;
            ALU_LH, ALU_LHU, ALU_SH: begin
                sel        = addr_lo[1] ? 4'b1100 : 4'b0011;
                misaligned = addr_lo[0];
            end
            ALU_LW, ALU_SW: begin
                sel        = 4'b1111;
                misaligned = |addr_lo;
            end
            default: ;
        endcase

        // Stores replicate the source across every lane so memory can pick by bus_sel.
        case (op)
            ALU_SB:  wdata      = {4{store_data[7:0]}};
            ALU_SH:  wdata      = {2{store_data[15:0]}};
            ALU_SW:  wdata      = store_data;
            ALU_LB:  load_value = {{24{lane_byte[7]}}, lane_byte};
            ALU_LBU: load_value = {24'h0, lane_byte};
            ALU_LH:  load_value = {{16{lane_half[15]}}, lane_half};
            ALU_LHU: load_value = {16'h0, lane_half};
            ALU_LW:  load_value = rdata;
            default: ;
        endcase
    end

endmodule

// File: rtl/t08_lsu.sv
// Load/store unit: runs one bus transaction per memory op, with timeout and
// misalignment errors reported alongside a one-cycle done pulse.
module t08_lsu
    import t08_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       mem_op,
    input  logic [31:0]      address,
    input  logic [31:0]      store_data,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [31:0]      load_data,
    t08_lsu_if.master        bus
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    lsu_state_t   state;
    lsu_state_t   state_next;
    logic [5:0]   op_q;
    logic [31:0]  addr_q;
    logic [31:0]  data_q;
    logic [CW-1:0] count;

    logic         accept;
    logic [5:0]   align_op;
    logic [1:0]   align_lo;
    logic [31:0]  align_data;
    logic         misaligned;
    logic [3:0]   sel;
    logic [31:0]  wdata;
    logic [31:0]  load_value;

    assign accept = (state == IDLE) && start && is_mem_op(mem_op);

    // While idle the aligner sees the incoming request, so misalignment is
    // decided in the same cycle the op is accepted.
    assign align_op   = (state == IDLE) ? mem_op        : op_q;
    assign align_lo   = (state == IDLE) ? address[1:0]  : addr_q[1:0];
    assign align_data = (state == IDLE) ? store_data    : data_q;

    t08_lsu_align u_align (
        .op         (align_op),
        .addr_lo    (align_lo),
        .store_data (align_data),
        .rdata      (bus.bus_rdata),
        .misaligned (misaligned),
        .sel        (sel),
        .wdata      (wdata),
        .load_value (load_value)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            count     <= '0;
            load_data <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_q   <= mem_op;
                addr_q <= address;
                data_q <= store_data;
            end
            if (state == WAIT && !bus.bus_ack)
                count <= count + 1'b1;
            else
                count <= '0;
            if (state == WAIT && bus.bus_ack && !is_store(op_q))
                load_data <= load_value;
        end
    end

    always_comb begin
        state_next     = state;
        busy           = (state != IDLE);
        done           = 1'b0;
        error          = 1'b0;
        bus.bus_req    = 1'b0;
        bus.bus_we     = 1'b0;
        bus.bus_addr   = 32'h0;
        bus.bus_sel    = 4'b0000;
        bus.bus_wdata  = 32'h0;

        case (state)
            IDLE: begin
                if (accept)
                    state_next = misaligned ? ERR : WAIT;
            end
            WAIT: begin
                bus.bus_req   = 1'b1;
                bus.bus_we    = is_store(op_q);
                bus.bus_addr  = {addr_q[31:2], 2'b00};
                bus.bus_sel   = sel;
                bus.bus_wdata = wdata;
                // An ack on the last counted cycle still completes normally.
                if (bus.bus_ack)
                    state_next = DONE;
                else if (count == CW'(TIMEOUT_CYCLES - 1))
                    state_next = ERR;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            ERR: begin
                done       = 1'b1;
                error      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_t08_lsu.sv
// Self-checking bench for t08_lsu: directed cases plus randomized memory ops
// compared against a plain-arithmetic reference of the load/store rules.
module tb_t08_lsu;

    logic        clk;
    logic        rst;
    logic        start;
    logic [5:0]  mem_op;
    logic [31:0] address;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] load_data;

    int checks   = 0;
    int failures = 0;
    logic [31:0] ld_model = 32'h0;

    t08_lsu_if bus_if ();

    t08_lsu #(.TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mem_op     (mem_op),
        .address    (address),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .load_data  (load_data),
        .bus        (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic ref_valid(input logic [5:0] op);
        return (op >= 6'd20) && (op <= 6'd27);
    endfunction

    function automatic logic ref_store(input logic [5:0] op);
        return (op >= 6'd25) && (op <= 6'd27);
    endfunction

    function automatic logic ref_misaligned(input logic [5:0] op, input logic [31:0] a);
        case (op)
            6'd21, 6'd24, 6'd26: return (a % 2) != 0;
            6'd22, 6'd27:        return (a % 4) != 0;
            default:             return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] ref_sel(input logic [5:0] op, input logic [31:0] a);
        int unsigned off;
        off = a % 4;
        case (op)
            6'd20, 6'd23, 6'd25: return 4'(1 << off);
            6'd21, 6'd24, 6'd26: return (off >= 2) ? 4'b1100 : 4'b0011;
            default:             return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [5:0] op, input logic [31:0] d);
        int unsigned b, h;
        b = d % 256;
        h = d % 65536;
        case (op)
            6'd25:   return b * 32'h01010101;
            6'd26:   return h * 32'h00010001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [31:0] a, input logic [31:0] rd);
        int unsigned b, h;
        b = (rd >> (8 * (a % 4))) % 256;
        h = (rd >> (16 * ((a % 4) / 2))) % 65536;
        case (op)
            6'd20:   return (b >= 128) ? b - 256 : b;
            6'd21:   return (h >= 32768) ? h - 65536 : h;
            6'd22:   return rd;
            6'd23:   return b;
            6'd24:   return h;
            default: return 32'h0;
        endcase
    endfunction

    // One complete op from a negedge to the negedge after it has settled back to idle.
    task automatic applyStimulus(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                                 input int delay, input logic [31:0] rdata);
        start      = 1'b1;
        mem_op     = op;
        address    = addr;
        store_data = sdata;
        @(negedge clk);
        start      = 1'b0;
        mem_op     = 6'($urandom);
        address    = $urandom;
        store_data = $urandom;

        if (!ref_valid(op)) begin
            checkOutput("ignored_busy", busy, 0);
            checkOutput("ignored_req", bus_if.bus_req, 0);
            checkOutput("ignored_done", done, 0);
            checkOutput("ignored_load_data", load_data, ld_model);
            return;
        end

        if (ref_misaligned(op, addr)) begin
            checkOutput("mis_done", done, 1);
            checkOutput("mis_error", error, 1);
            checkOutput("mis_req", bus_if.bus_req, 0);
            checkOutput("mis_load_data", load_data, ld_model);
            @(negedge clk);
            checkOutput("mis_done_clear", done, 0);
            checkOutput("mis_idle", busy, 0);
            checkOutput("mis_req_after", bus_if.bus_req, 0);
            return;
        end

        checkOutput("req_high", bus_if.bus_req, 1);
        checkOutput("busy_high", busy, 1);
        checkOutput("no_early_done", done, 0);
        checkOutput("bus_addr", bus_if.bus_addr, addr - (addr % 4));
        checkOutput("bus_we", bus_if.bus_we, ref_store(op));
        checkOutput("bus_sel", bus_if.bus_sel, ref_sel(op, addr));
        if (ref_store(op))
            checkOutput("bus_wdata", bus_if.bus_wdata, ref_wdata(op, sdata));

        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            checkOutput("req_held", bus_if.bus_req, 1);
            checkOutput("addr_stable", bus_if.bus_addr, addr - (addr % 4));
        end

        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = rdata;
        @(negedge clk);
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = $urandom;
        if (!ref_store(op))
            ld_model = ref_load(op, addr, rdata);

        checkOutput("done_pulse", done, 1);
        checkOutput("done_error", error, 0);
        checkOutput("done_req_low", bus_if.bus_req, 0);
        checkOutput("load_data", load_data, ld_model);
        @(negedge clk);
        checkOutput("done_clear", done, 0);
        checkOutput("back_idle", busy, 0);
    endtask

    initial begin
        int n_req;
        int bound;

        rst              = 1'b1;
        start            = 1'b1;
        mem_op           = 6'd22;
        address          = 32'h0;
        store_data       = 32'h0;
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = 32'h0;

        // Reset wins over a simultaneous start.
        @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_error", error, 0);
        checkOutput("rst_load_data", load_data, 0);
        checkOutput("rst_req", bus_if.bus_req, 0);
        checkOutput("rst_we", bus_if.bus_we, 0);
        checkOutput("rst_addr", bus_if.bus_addr, 0);
        checkOutput("rst_sel", bus_if.bus_sel, 0);
        checkOutput("rst_wdata", bus_if.bus_wdata, 0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);

        applyStimulus(6'd27, 32'h100, 32'hDEADBEEF, 2, 32'h0);
        applyStimulus(6'd20, 32'h103, 32'h0, 1, 32'h80FF7F01);
        checkOutput("lb_103", load_data, 32'hFFFFFF80);
        applyStimulus(6'd23, 32'h103, 32'h0, 0, 32'h80FF7F01);
        checkOutput("lbu_103", load_data, 32'h00000080);
        applyStimulus(6'd20, 32'h100, 32'h0, 3, 32'h80FF7F01);
        checkOutput("lb_100", load_data, 32'h00000001);
        applyStimulus(6'd21, 32'h102, 32'h0, 1, 32'h80011234);
        checkOutput("lh_102", load_data, 32'hFFFF8001);
        applyStimulus(6'd24, 32'h102, 32'h0, 1, 32'h80011234);
        checkOutput("lhu_102", load_data, 32'h00008001);
        applyStimulus(6'd21, 32'h101, 32'h0, 0, 32'h80011234);
        applyStimulus(6'd25, 32'h201, 32'h123456AB, 1, 32'h0);
        applyStimulus(6'd26, 32'h202, 32'h0000BEEF, 1, 32'h0);
        applyStimulus(6'd27, 32'h102, 32'h0, 0, 32'h0);
        applyStimulus(6'd22, 32'h44, 32'h0, 15, 32'hCAFEF00D);
        applyStimulus(6'd1, 32'h40, 32'h5, 0, 32'h0);

        // Timeout: no ack ever arrives.
        start   = 1'b1;
        mem_op  = 6'd22;
        address = 32'h40;
        @(negedge clk);
        start = 1'b0;
        n_req = 0;
        bound = 0;
        while (!done && bound < 40) begin
            if (bus_if.bus_req) n_req++;
            @(negedge clk);
            bound++;
        end
        checkOutput("to_done_seen", done, 1);
        checkOutput("to_req_cycles", n_req, 16);
        checkOutput("to_error", error, 1);
        checkOutput("to_req_low", bus_if.bus_req, 0);
        checkOutput("to_load_data", load_data, ld_model);
        @(negedge clk);
        checkOutput("to_done_clear", done, 0);

        // A second start during WAIT must be dropped.
        start   = 1'b1;
        mem_op  = 6'd22;
        address = 32'h300;
        @(negedge clk);
        mem_op     = 6'd27;
        address    = 32'h500;
        store_data = 32'h99999999;
        @(negedge clk);
        start = 1'b0;
        checkOutput("dbl_addr", bus_if.bus_addr, 32'h300);
        checkOutput("dbl_we", bus_if.bus_we, 0);
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 32'h11223344;
        @(negedge clk);
        bus_if.bus_ack = 1'b0;
        ld_model = 32'h11223344;
        checkOutput("dbl_done", done, 1);
        checkOutput("dbl_load_data", load_data, ld_model);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("dbl_no_second_req", bus_if.bus_req, 0);
            checkOutput("dbl_no_second_done", done, 0);
        end

        // Reset in the middle of WAIT aborts without a done pulse.
        start   = 1'b1;
        mem_op  = 6'd21;
        address = 32'h10;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ld_model = 32'h0;
        checkOutput("wrst_req", bus_if.bus_req, 0);
        checkOutput("wrst_busy", busy, 0);
        checkOutput("wrst_done", done, 0);
        checkOutput("wrst_load_data", load_data, 0);
        @(negedge clk);
        checkOutput("wrst_no_late_done", done, 0);

        for (int i = 0; i < 40; i++) begin
            logic [5:0]  op;
            logic [31:0] a;
            op = 6'($urandom_range(20, 27));
            if ($urandom_range(0, 9) == 0) op = 6'($urandom_range(1, 19));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a - (a % 4);
            applyStimulus(op, a, $urandom, int'($urandom_range(0, 6)), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/t08_lsu.md
Name: t08_lsu

Overview:
- Load/store unit that consumes the ALU result for memory ops (codes 20-27). `address` is the ALU `data_out`, computed as reg1 + immediate. `store_data` is reg2.
- Runs a single request/acknowledge transaction on the word-wide data bus.
- Steers byte lanes, generates byte selects, and sign- or zero-extends load data.
- Returns the result to the datapath with a one-cycle `done` pulse.

Parameters:
- TIMEOUT_CYCLES, 16: number of cycles `bus_req` may stay high without `bus_ack` before the operation aborts with error.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request from control to begin a memory op
- mem_op  in  6  ALU operation code: LB=20, LH=21, LW=22, LBU=23, LHU=24, SB=25, SH=26, SW=27
- address  in  32  effective byte address (ALU data_out)
- store_data  in  32  store source (reg2); low byte/half used for SB/SH
- busy  out  1  high whenever the FSM is not in IDLE
- done  out  1  one-cycle completion pulse
- error  out  1  valid with done; misaligned access or timeout
- load_data  out  32  extended load result; holds until the next successful load
- bus_req  out  1  bus request; held until ack
- bus_we  out  1  1 = write
- bus_addr  out  32  word address {address[31:2], 2'b00}
- bus_wdata  out  32  lane-replicated write data
- bus_sel  out  4  byte enables
- bus_rdata  in  32  read data, valid when bus_ack=1
- bus_ack  in  1  one-cycle acknowledge

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, timeout counter 0. Reset takes priority over every other event.
- States and transitions:
  - IDLE, start high, mem_op in 20..27: latch op, address and store_data.
    - Misaligned access goes to ERR. Misaligned means LH/LHU/SH with address[0]=1, or LW/SW with address[1:0]≠0.
    - Otherwise go to WAIT.
  - IDLE, start high, mem_op outside 20..27: ignored, stay IDLE.
  - WAIT: bus_req=1; bus_we, bus_addr, bus_sel, bus_wdata are driven from the latched values and stay stable.
    - Counter increments each WAIT cycle.
    - bus_ack=1: loads register the formatted result into load_data; go to DONE.
    - No ack and counter = TIMEOUT_CYCLES-1: go to ERR.
    - Ack on the final counted cycle wins over timeout.
  - DONE: done=1, error=0, bus_req=0; go to IDLE.
  - ERR: done=1, error=1, bus_req=0; load_data unchanged; go to IDLE.
- start is ignored in WAIT, DONE and ERR; there is no queueing.
- Latency:
  - start sampled at edge 0 → bus_req high after edge 0.
  - ack sampled at edge k → done high for the cycle after edge k.
  - Misaligned: done/error high for the cycle after edge 0; bus_req never rises.
- bus_sel:
  - byte ops: 1 << address[1:0]
  - half ops: 0011 if address[1]=0, else 1100
  - word ops: 1111
  - Loads drive bus_sel the same way as stores.
- bus_wdata: SB replicates byte ×4, SH replicates half ×2, SW passes data through.
- Load formatting:
  - Select the byte lane address[1:0] or half lane address[1].
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes bus_rdata through.
- Stores never modify load_data.
- Reset during WAIT: bus_req, busy and done are 0 after that edge; no done pulse is produced for the aborted op.

Decomposition:
- Shared package t08_pkg holds:
  - the alu_operations enum (codes 1-35, shared with the ALU and decoder)
  - lsu_state_t {IDLE, WAIT, DONE, ERR}
- Sub-module t08_lsu_align is purely combinational. It computes:
  - misaligned flag
  - bus_sel and bus_wdata from (op, address[1:0], store_data)
  - extended load value from (op, address[1:0], bus_rdata)
- t08_lsu keeps the FSM, latches, counter and load_data register.

Test Plan:
- SW, address 0x100, data 0xDEADBEEF, ack 2 cycles after bus_req → bus_addr 0x100, bus_sel 1111, bus_we 1, bus_wdata 0xDEADBEEF; done the cycle after ack; error 0; load_data unchanged.
- bus_rdata 0x80FF7F01:
  - LB, address 0x103 → load_data 0xFFFFFF80
  - LBU, address 0x103 → 0x00000080
  - LB, address 0x100 → 0x00000001
- bus_rdata 0x80011234:
  - LH, address 0x102 → 0xFFFF8001
  - LHU, address 0x102 → 0x00008001
  - LH, address 0x101 → done+error one cycle after start; bus_req never high.
- SB, address 0x201, store_data 0x123456AB → bus_addr 0x200, bus_sel 0010, bus_wdata 0xABABABAB.
- SH, address 0x202, store_data 0x0000BEEF → bus_sel 1100, bus_wdata 0xBEEFBEEF.
- LW, address 0x40, never ack (TIMEOUT_CYCLES=16) → bus_req high exactly 16 cycles, then done=1, error=1, bus_req=0.
- Mid-op control cases:
  - Second start during WAIT → ignored; only one done pulse.
  - rst asserted in WAIT → next cycle bus_req=0, busy=0, done=0, load_data=0.
  - start with mem_op=1 (ADD) → no activity.
